// File: rtl/pic_pkg.sv
// Shared constants and priority helper for the nested interrupt controller.
package pic_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_IMR      = 2'd1;
  localparam logic [1:0] ADDR_EOI_IRR  = 2'd2;
  localparam logic [1:0] ADDR_PRIO_ISR = 2'd3;

  localparam int CTRL_LTIM = 16;
  localparam int CTRL_AEOI = 17;
  localparam int CTRL_ROT  = 18;

  localparam int EOI_SL    = 8;
  localparam int EOI_LVL_W = 5;

  // Rank 0 is the highest priority: the id just after the lowest-priority pointer.
  function automatic logic [5:0] prio_rank(input logic [4:0] id, input logic [4:0] lp, input int n);
    int r;
    r = (int'(id) - int'(lp) - 1 + 2 * n) % n;
    return r[5:0];
  endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Picks the highest-priority set bit of a request vector under a rotating pointer.
module pic_prio_resolver
  import pic_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [4:0]   lp,
  output logic         found,
  output logic [4:0]   id
);

  logic [5:0] best_rank;

  always_comb begin
    found     = 1'b0;
    id        = '0;
    best_rank = 6'(N);
    for (int i = 0; i < N; i++) begin
      if (req[i] && (prio_rank(5'(i), lp, N) < best_rank)) begin
        found     = 1'b1;
        id        = 5'(i);
        best_rank = prio_rank(5'(i), lp, N);
      end
    end
  end

endmodule

// File: rtl/pic_nested_ctrl.sv
// Fully-nested interrupt controller with edge/level latching, masking and rotation.
module pic_nested_ctrl
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             int_o,
  input  logic             inta,
  output logic [VEC_W-1:0] vec_o,
  output logic             vec_valid
);

  localparam logic [N_IRQ-1:0] ONE      = {{(N_IRQ-1){1'b0}}, 1'b1};
  localparam logic [4:0]       LP_RESET = 5'(N_IRQ - 1);

  logic [N_IRQ-1:0] irr_reg, isr_reg, imr_reg, irq_q_reg;
  logic [N_IRQ-1:0] irr_next, isr_next, pend;
  logic [N_IRQ-1:0] isr_clr, ack_set, irr_clr;
  logic [VEC_W-1:0] base_reg, vec_next;
  logic             ltim_reg, aeoi_reg, rot_reg;
  logic [4:0]       lp_reg, lp_next;
  logic             win_found, isr_found, int_cond, ack_ok;
  logic [4:0]       win_id, isr_id, eoi_lvl;
  logic             wr_eoi, wr_prio;
  logic [31:0]      ctrl_rd, rd_mux;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, reg_wdata};

  assign pend = irr_reg & ~imr_reg;

  pic_prio_resolver #(.N(N_IRQ)) u_pend_res (
    .req(pend), .lp(lp_reg), .found(win_found), .id(win_id)
  );

  pic_prio_resolver #(.N(N_IRQ)) u_isr_res (
    .req(isr_reg), .lp(lp_reg), .found(isr_found), .id(isr_id)
  );

  // Only a request strictly above everything in service may interrupt.
  assign int_cond = win_found &&
                    (!isr_found || (prio_rank(win_id, lp_reg, N_IRQ) < prio_rank(isr_id, lp_reg, N_IRQ)));
  assign ack_ok   = inta && int_o && int_cond;

  assign wr_eoi  = reg_wr && (reg_addr == ADDR_EOI_IRR);
  assign wr_prio = reg_wr && (reg_addr == ADDR_PRIO_ISR);
  assign eoi_lvl = reg_wdata[EOI_LVL_W-1:0];

  always_comb begin
    isr_clr = '0;
    ack_set = '0;
    irr_clr = '0;
    lp_next = lp_reg;
    if (wr_prio && (reg_wdata < 32'(N_IRQ)))
      lp_next = reg_wdata[4:0];
    if (wr_eoi) begin
      if (reg_wdata[EOI_SL]) begin
        if ({27'b0, eoi_lvl} < 32'(N_IRQ))
          isr_clr = ONE << eoi_lvl;
      end else if (isr_found) begin
        isr_clr = ONE << isr_id;
        if (rot_reg)
          lp_next = isr_id;
      end
    end
    if (ack_ok) begin
      irr_clr = ONE << win_id;
      if (!aeoi_reg)
        ack_set = ONE << win_id;
      else if (rot_reg)
        lp_next = win_id;
    end
    // Set wins over clear on both ISR and edge-mode IRR.
    isr_next = (isr_reg & ~isr_clr) | ack_set;
    irr_next = ltim_reg ? irq : ((irr_reg & ~irr_clr) | (irq & ~irq_q_reg));
    vec_next = ack_ok ? (base_reg + VEC_W'(win_id)) : (base_reg + VEC_W'(N_IRQ - 1));
  end

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[VEC_W-1:0]   = base_reg;
    ctrl_rd[CTRL_LTIM]   = ltim_reg;
    ctrl_rd[CTRL_AEOI]   = aeoi_reg;
    ctrl_rd[CTRL_ROT]    = rot_reg;
    case (reg_addr)
      ADDR_CTRL:    rd_mux = ctrl_rd;
      ADDR_IMR:     rd_mux = 32'(imr_reg);
      ADDR_EOI_IRR: rd_mux = 32'(irr_reg);
      default:      rd_mux = 32'(isr_reg);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irr_reg   <= '0;
      isr_reg   <= '0;
      imr_reg   <= '1;
      irq_q_reg <= '0;
      base_reg  <= '0;
      ltim_reg  <= 1'b0;
      aeoi_reg  <= 1'b0;
      rot_reg   <= 1'b0;
      lp_reg    <= LP_RESET;
      int_o     <= 1'b0;
      vec_o     <= '0;
      vec_valid <= 1'b0;
      reg_rdata <= '0;
    end else begin
      irr_reg   <= irr_next;
      isr_reg   <= isr_next;
      irq_q_reg <= irq;
      lp_reg    <= lp_next;
      // An acknowledge consumes the current request; int_o re-evaluates next cycle.
      int_o     <= inta ? 1'b0 : int_cond;
      vec_valid <= inta;
      if (inta)
        vec_o <= vec_next;
      if (reg_rd)
        reg_rdata <= rd_mux;
      if (reg_wr && (reg_addr == ADDR_CTRL)) begin
        base_reg <= reg_wdata[VEC_W-1:0];
        ltim_reg <= reg_wdata[CTRL_LTIM];
        aeoi_reg <= reg_wdata[CTRL_AEOI];
        rot_reg  <= reg_wdata[CTRL_ROT];
      end
      if (reg_wr && (reg_addr == ADDR_IMR))
        imr_reg <= reg_wdata[N_IRQ-1:0];
    end
  end

endmodule

// File: tb/tb_pic_nested_ctrl.sv
// Directed bench for pic_nested_ctrl: nesting, masking, rotation, spurious and reset.
module tb_pic_nested_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        int_o;
  logic        inta = 1'b0;
  logic [7:0]  vec_o;
  logic        vec_valid;

  int n_checks = 0;
  int n_fail   = 0;

  pic_nested_ctrl #(.N_IRQ(8), .VEC_W(8)) dut (
    .clk(clk), .rst(rst), .irq(irq),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .int_o(int_o), .inta(inta), .vec_o(vec_o), .vec_valid(vec_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 1'b0;
    $display("wr addr=%0d data=%h", a, d);
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    tick();
    reg_rd = 1'b0;
    d = reg_rdata;
    $display("rd addr=%0d data=%h", a, d);
  endtask

  task automatic do_ack(output logic [7:0] v, output logic vv);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    v  = vec_o;
    vv = vec_valid;
    $display("ack vec=%h valid=%b", v, vv);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq = m;
    tick();
    irq = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    if (int_o !== 1'b0) begin n_fail++; $display("FAIL reset_int_o got %b want 0", int_o); end
    n_checks++;
    if (vec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vec_valid got %b want 0", vec_valid); end
    n_checks++;
    if (vec_o !== 8'h00) begin n_fail++; $display("FAIL reset_vec_o got %h want 00", vec_o); end
    n_checks++;
    if (reg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", reg_rdata); end
    n_checks++;
    reg_read(2'd1, d);
    if (d !== 32'hFF) begin n_fail++; $display("FAIL reset_imr got %h want ff", d); end
    n_checks++;
    reg_read(2'd0, d);
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", d); end
    n_checks++;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [7:0]  v;
    logic        vv;
    reg_write(2'd1, 32'h00);
    reg_write(2'd0, 32'hA8);
    pulse_irq(8'h01);
    if (int_o !== 1'b0) begin n_fail++; $display("FAIL basic_int_early got %b want 0", int_o); end
    n_checks++;
    tick();
    if (int_o !== 1'b1) begin n_fail++; $display("FAIL basic_int got %b want 1", int_o); end
    n_checks++;
    do_ack(v, vv);
    if (vv !== 1'b1 || v !== 8'hA8) begin n_fail++; $display("FAIL basic_ack got %h/%b want a8/1", v, vv); end
    n_checks++;
    tick();
    if (vec_valid !== 1'b0 || vec_o !== 8'hA8) begin n_fail++; $display("FAIL basic_vec_hold got %h/%b want a8/0", vec_o, vec_valid); end
    n_checks++;
    reg_read(2'd3, d);
    if (d !== 32'h01) begin n_fail++; $display("FAIL basic_isr got %h want 01", d); end
    n_checks++;
    if (int_o !== 1'b0) begin n_fail++; $display("FAIL basic_int_after_ack got %b want 0", int_o); end
    n_checks++;
    reg_write(2'd2, 32'h000);
    reg_read(2'd3, d);
    if (d !== 32'h00) begin n_fail++; $display("FAIL basic_eoi got %h want 00", d); end
    n_checks++;
  endtask

  task automatic test_nesting();
    logic [31:0] d;
    logic [7:0]  v;
    logic        vv;
    pulse_irq(8'h08);
    tick();
    do_ack(v, vv);
    if (v !== 8'hAB) begin n_fail++; $display("FAIL nest_ack3 got %h want ab", v); end
    n_checks++;
    pulse_irq(8'h20);
    tick(); tick();
    if (int_o !== 1'b0) begin n_fail++; $display("FAIL nest_blocked got %b want 0", int_o); end
    n_checks++;
    pulse_irq(8'h02);
    tick();
    if (int_o !== 1'b1) begin n_fail++; $display("FAIL nest_preempt got %b want 1", int_o); end
    n_checks++;
    do_ack(v, vv);
    if (v !== 8'hA9) begin n_fail++; $display("FAIL nest_ack1 got %h want a9", v); end
    n_checks++;
    reg_read(2'd3, d);
    if (d !== 32'h0A) begin n_fail++; $display("FAIL nest_isr got %h want 0a", d); end
    n_checks++;
    reg_write(2'd2, 32'h101);
    reg_read(2'd3, d);
    if (d !== 32'h08) begin n_fail++; $display("FAIL nest_specific_eoi got %h want 08", d); end
    n_checks++;
    reg_write(2'd2, 32'h000);
    tick();
    if (int_o !== 1'b1) begin n_fail++; $display("FAIL nest_release got %b want 1", int_o); end
    n_checks++;
    do_ack(v, vv);
    if (v !== 8'hAD) begin n_fail++; $display("FAIL nest_ack5 got %h want ad", v); end
    n_checks++;
    reg_write(2'd2, 32'h000);
  endtask

  task automatic test_masking();
    logic [31:0] d;
    logic [7:0]  v;
    logic        vv;
    reg_write(2'd1, 32'h20);
    pulse_irq(8'h20);
    tick();
    if (int_o !== 1'b0) begin n_fail++; $display("FAIL mask_int got %b want 0", int_o); end
    n_checks++;
    reg_read(2'd2, d);
    if (d !== 32'h20) begin n_fail++; $display("FAIL mask_irr got %h want 20", d); end
    n_checks++;
    reg_write(2'd1, 32'h00);
    if (int_o !== 1'b0) begin n_fail++; $display("FAIL unmask_early got %b want 0", int_o); end
    n_checks++;
    tick();
    if (int_o !== 1'b1) begin n_fail++; $display("FAIL unmask_int got %b want 1", int_o); end
    n_checks++;
    do_ack(v, vv);
    if (v !== 8'hAD) begin n_fail++; $display("FAIL mask_ack got %h want ad", v); end
    n_checks++;
    reg_write(2'd2, 32'h000);
  endtask

  task automatic test_rotation();
    logic [31:0] d;
    logic [7:0]  v;
    logic        vv;
    irq = 8'h05;
    reg_write(2'd0, 32'h0005_00A8);
    tick(); tick();
    if (int_o !== 1'b1) begin n_fail++; $display("FAIL rot_int got %b want 1", int_o); end
    n_checks++;
    do_ack(v, vv);
    if (v !== 8'hA8) begin n_fail++; $display("FAIL rot_ack0 got %h want a8", v); end
    n_checks++;
    reg_write(2'd2, 32'h000);
    tick();
    if (int_o !== 1'b1) begin n_fail++; $display("FAIL rot_int2 got %b want 1", int_o); end
    n_checks++;
    do_ack(v, vv);
    if (v !== 8'hAA) begin n_fail++; $display("FAIL rot_ack2 got %h want aa", v); end
    n_checks++;
    irq = 8'h00;
    reg_write(2'd2, 32'h000);
    reg_read(2'd3, d);
    if (d !== 32'h00) begin n_fail++; $display("FAIL rot_isr got %h want 00", d); end
    n_checks++;
    reg_write(2'd0, 32'hA8);
    reg_write(2'd3, 32'h7);
  endtask

  task automatic test_spurious();
    logic [31:0] d;
    logic [7:0]  v;
    logic        vv;
    do_ack(v, vv);
    if (vv !== 1'b1 || v !== 8'hAF) begin n_fail++; $display("FAIL spur_vec got %h/%b want af/1", v, vv); end
    n_checks++;
    reg_read(2'd3, d);
    if (d !== 32'h00) begin n_fail++; $display("FAIL spur_isr got %h want 00", d); end
    n_checks++;
    reg_write(2'd0, 32'h0002_00A8);
    pulse_irq(8'h10);
    tick();
    do_ack(v, vv);
    if (v !== 8'hAC) begin n_fail++; $display("FAIL aeoi_vec got %h want ac", v); end
    n_checks++;
    reg_read(2'd3, d);
    if (d !== 32'h00) begin n_fail++; $display("FAIL aeoi_isr got %h want 00", d); end
    n_checks++;
    reg_write(2'd0, 32'hA8);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    pulse_irq(8'h01);
    tick();
    inta = 1'b1;
    tick();
    inta = 1'b0;
    if (vec_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid got %b want 1", vec_valid); end
    n_checks++;
    #1 rst = 1'b1;
    #1;
    if (vec_valid !== 1'b0 || int_o !== 1'b0) begin n_fail++; $display("FAIL arst_outputs got %b/%b want 0/0", vec_valid, int_o); end
    n_checks++;
    tick();
    rst = 1'b0;
    reg_read(2'd1, d);
    if (d !== 32'hFF) begin n_fail++; $display("FAIL arst_imr got %h want ff", d); end
    n_checks++;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_nesting();
    test_masking();
    test_rotation();
    test_spurious();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_nested_ctrl.md
# pic_nested_ctrl

Parametrised, synchronous successor to the 8259A-style controller in this codebase. It latches up to N_IRQ requests in edge or level mode and masks them. It resolves them with fully-nested, optionally rotating priority, and returns a vector for a single-cycle acknowledge. It sits between peripheral interrupt lines and the CPU core, programmed over a small register port.

## Interface
- N_IRQ, 8, number of request lines, legal range 2..32
- VEC_W, 8, vector width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- irq  in  N_IRQ  request lines, already synchronous to clk
- reg_wr  in  1  register write strobe
- reg_rd  in  1  register read strobe
- reg_addr  in  2  register select
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, registered
- int_o  out  1  interrupt to CPU, registered
- inta  in  1  acknowledge, one-cycle pulse
- vec_o  out  VEC_W  acknowledged vector
- vec_valid  out  1  one-cycle pulse qualifying vec_o

## Operation
- Registers (reset value):
  - addr 0 CTRL RW (0): [VEC_W-1:0] vector base; bit16 LTIM (1 = level); bit17 AEOI; bit18 ROT (rotate on EOI)
  - addr 1 IMR RW (all ones, every line masked)
  - addr 2 write = EOI command, read = IRR. EOI fields: bit8 SL (1 = specific), [4:0] level.
  - addr 3 write = set-priority ([4:0] becomes lowest-priority id), read = ISR
- State: IRR, ISR, IMR, CTRL, irq_q, lp (lowest-priority pointer, reset N_IRQ-1, so id 0 is highest).
- Priority order: lp+1, lp+2, … lp, all mod N_IRQ.
- Set-priority writes with value ≥ N_IRQ are ignored.
- IRR in edge mode: bit set on irq & ~irq_q; bit cleared on acknowledge of that id. A set and a clear in the same cycle resolve to set.
- IRR in level mode: IRR = irq every cycle. The acknowledge does not clear it.
- pend = IRR & ~IMR. Winner = highest-priority pend bit.
- int_o is set next cycle when a winner exists and its priority is strictly higher than the highest-priority ISR bit (fully nested). Otherwise it is cleared next cycle.
- Acknowledge (inta high) with a valid winner:
  - vec_o = base + id, modulo 2^VEC_W
  - ISR[id] set, unless AEOI
  - with AEOI and ROT set, lp = id
- Acknowledge with no valid winner (request withdrawn or inta while int_o low): spurious vector base + N_IRQ-1. ISR and IRR are unchanged.
- Non-specific EOI clears the highest-priority ISR bit; with ROT set, lp becomes that id.
- Specific EOI clears ISR[level]. level ≥ N_IRQ is ignored.
- EOI with ISR empty has no effect.
- EOI and acknowledge in the same cycle: the EOI is computed on the pre-cycle ISR, the acknowledge sets its bit, and set wins on collision.
- Masking never alters ISR. Masked lines still latch into IRR.
- reg_wr and reg_rd in the same cycle: both are performed; rdata shows the pre-write value.

## Timing
- Reset values:
  - int_o 0, vec_o 0, vec_valid 0, reg_rdata 0
  - IRR 0, ISR 0, CTRL 0, IMR all ones, lp N_IRQ-1
- Edge latency: irq rises before edge k → IRR set after edge k → int_o high after edge k+1.
- Acknowledge at edge k:
  - vec_o and vec_valid valid after edge k, for one cycle; vec_o holds its value afterwards
  - int_o recomputed from post-ack state, reflected after edge k+1
- EOI or IMR write at edge k: int_o reflects it after edge k+1.
- reg_rdata updates after the edge sampling reg_rd and holds until the next read.
- Reset mid-sequence: all state returns to reset values immediately. A pending vec_valid is dropped.

## Structure
- Package pic_pkg:
  - register address localparams
  - CTRL bit positions (LTIM, AEOI, ROT)
  - EOI field positions
  - a function computing rotated priority rank
- Sub-module pic_prio_resolver (combinational; inputs vector and lp; outputs found flag and id). Two instances: one on pend, one on ISR.

## Test plan
- Reset; write IMR=0x00, CTRL base=0xA8; pulse irq[0]; pulse inta → int_o high 2 cycles after the edge, vec_o=0xA8, ISR=0x01; non-specific EOI → ISR=0x00.
- Nesting: irq[3] acknowledged (ISR=0x08); raise irq[5] → int_o stays low. Raise irq[1] → int_o high; acknowledge → vec_o=0xA9, ISR=0x0A.
- Masking: IMR=0x20, raise irq[5] → int_o low, IRR read=0x20; IMR=0x00 → int_o high after 2 cycles.
- Rotation: ROT=1, irq[0] and irq[2] held in level mode; acknowledge id 0; EOI → lp=0; next acknowledge → vec_o=base+2.
- Spurious: inta with int_o low → vec_o=base+N_IRQ-1, ISR unchanged; AEOI=1 acknowledge of irq[4] → ISR stays 0.
- Async reset asserted mid-acknowledge → vec_valid, int_o 0 immediately; IMR reads 0xFF.
